// File: rtl/memsplit_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : memsplit_initiator
//  Description : MemSplit32 bus-master front end. Commands arrive on a
//                valid/ready port and are queued in an in-order FIFO. They are
//                issued as MemSplit32 requests. Reads are tracked until their
//                response returns, and completions are reported in order.
//                Silent slaves are retired with an error after RESP_TIMEOUT
//                idle cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_i            clock (rising edge), async active-high reset
//    cmd_valid_i/ready_o     command handshake (ready = FIFO not full)
//    cmd_we_i, cmd_addr_bi,
//    cmd_wdata_bi, cmd_be_bi command fields
//    bus_req_o ... bus_be_bo MemSplit32 master request side
//    bus_ack_i, bus_resp_i,
//    bus_rdata_bi            MemSplit32 slave acknowledge / read response
//    rsp_valid_o/rdata_bo/
//    err_o                   one-cycle read completion (err = timed out)
//    busy_o                  commands queued or reads outstanding
// ============================================================================
module memsplit_initiator #(
    parameter int CMD_FIFO_POW    = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESP_TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_bi,
    input  logic [31:0] cmd_wdata_bi,
    input  logic [3:0]  cmd_be_bi,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_bo,
    output logic [31:0] bus_wdata_bo,
    output logic [3:0]  bus_be_bo,
    input  logic        bus_ack_i,
    input  logic        bus_resp_i,
    input  logic [31:0] bus_rdata_bi,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_bo,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int DEPTH = 1 << CMD_FIFO_POW;
    localparam int PTR_W = CMD_FIFO_POW;
    localparam int CNT_W = CMD_FIFO_POW + 1;
    localparam int OUT_W = 3;

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH);
    localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
    // The counter starts at 0 in the first waiting cycle, so the last value
    // before retiring is RESP_TIMEOUT-1 (RESP_TIMEOUT silent cycles in total).
    localparam logic [15:0]      TMO_LAST  = 16'(RESP_TIMEOUT - 1);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    cmd_t             fifo_q [DEPTH];
    cmd_t             fifo_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    cmd_t head;
    logic fifo_empty;
    logic push;
    logic pop;
    logic rd_issue;
    logic resp_take;
    logic tmo_hit;

    always_comb begin
        head       = fifo_q[rd_ptr_q];
        fifo_empty = (count_q == '0);

        // Only reads are throttled by the outstanding limit; a write at the
        // head is always presented.
        bus_req_o    = !fifo_empty && !(!head.we && (outst_q == OUT_MAX));
        bus_we_o     = head.we;
        bus_addr_bo  = head.addr;
        bus_wdata_bo = head.wdata;
        bus_be_bo    = head.be;

        push      = cmd_valid_i && !full_q;
        pop       = bus_req_o && bus_ack_i;
        rd_issue  = pop && !head.we;
        resp_take = bus_resp_i && (outst_q != '0);
        // A response arriving in the same cycle takes precedence over expiry.
        tmo_hit   = (outst_q != '0) && !bus_resp_i && (tmo_q == TMO_LAST);

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {cmd_we_i, cmd_addr_bi, cmd_wdata_bi, cmd_be_bi};
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d   = (count_d == FIFO_FULL);

        outst_d = outst_q + OUT_W'(rd_issue) - OUT_W'(resp_take || tmo_hit);

        if (bus_resp_i || tmo_hit || (outst_q == '0)) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        rsp_valid_d = resp_take || tmo_hit;
        rsp_err_d   = tmo_hit;
        if (resp_take) begin
            rsp_rdata_d = bus_rdata_bi;
        end else if (tmo_hit) begin
            rsp_rdata_d = '0;
        end else begin
            rsp_rdata_d = rsp_rdata_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            outst_q     <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            outst_q     <= outst_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready_o  = !full_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_bo = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (count_q != '0) || (outst_q != '0);

endmodule
`default_nettype wire
